// File: rtl/riscv_alu_arbiter_if.sv
// rtl/riscv_alu_arbiter_if.sv - requester, response and shared-ALU signal bundle for riscv_alu_arbiter
//
// Purpose: groups every non-clock/reset signal of the arbiter.
// slave  modport : the arbiter itself.
// master modport : the surrounding logic (requesters, response sinks, shared ALU).
// Signals:
//   req_valid/req_ready   per-requester operation handshake
//   req_fun/req_data1/2   per-requester ALU function and packed operands
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_alu_out/br_flag   shared result bus
//   alu_exec_fun/data1/2  drive to the shared ALU
//   alu_out/alu_br_flag   return from the shared ALU
//   busy                  arbiter not idle
interface riscv_alu_arbiter_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REQ     = 2,
    parameter int FUN_W       = 4
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0][FUN_W-1:0]    req_fun;
    logic [NUM_REQ*WORD_LENGTH-1:0]   req_data1;
    logic [NUM_REQ*WORD_LENGTH-1:0]   req_data2;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ-1:0]               rsp_ready;
    logic [WORD_LENGTH-1:0]           rsp_alu_out;
    logic                             rsp_br_flag;
    logic [FUN_W-1:0]                 alu_exec_fun;
    logic [WORD_LENGTH-1:0]           alu_data1;
    logic [WORD_LENGTH-1:0]           alu_data2;
    logic [WORD_LENGTH-1:0]           alu_out;
    logic                             alu_br_flag;
    logic                             busy;

    modport slave (
        input  req_valid, req_fun, req_data1, req_data2, rsp_ready, alu_out, alu_br_flag,
        output req_ready, rsp_valid, rsp_alu_out, rsp_br_flag,
               alu_exec_fun, alu_data1, alu_data2, busy
    );

    modport master (
        output req_valid, req_fun, req_data1, req_data2, rsp_ready, alu_out, alu_br_flag,
        input  req_ready, rsp_valid, rsp_alu_out, rsp_br_flag,
               alu_exec_fun, alu_data1, alu_data2, busy
    );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// rtl/riscv_alu_arbiter.sv - round-robin sharing of one riscv_alu between NUM_REQ requesters
//
// Purpose: picks one requester round-robin, registers its operands, drives the
// shared ALU from those registers, captures the ALU result and returns it to
// the winner over a valid/ready response channel. One operation in flight.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    riscv_alu_arbiter_if.slave (request, response and ALU signals)
module riscv_alu_arbiter #(
    parameter int               WORD_LENGTH = 32,
    parameter int               NUM_REQ     = 2,
    parameter int               FUN_W       = 4,
    parameter logic [FUN_W-1:0] ALU_ADD     = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_alu_arbiter_if.slave   bus
);
    localparam int RW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [RW-1:0]          rr_ptr_q,  rr_ptr_d;
    logic [RW-1:0]          gnt_id_q,  gnt_id_d;
    logic [FUN_W-1:0]       fun_q,     fun_d;
    logic [WORD_LENGTH-1:0] data1_q,   data1_d;
    logic [WORD_LENGTH-1:0] data2_q,   data2_d;
    logic [WORD_LENGTH-1:0] res_out_q, res_out_d;
    logic                   res_br_q,  res_br_d;

    logic                   arb_any;
    logic [RW-1:0]          arb_idx;
    int                     arb_cand;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        arb_any  = 1'b0;
        arb_idx  = '0;
        arb_cand = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!arb_any && bus.req_valid[arb_cand]) begin
                arb_any = 1'b1;
                arb_idx = RW'(arb_cand);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gnt_id_q  <= '0;
            fun_q     <= ALU_ADD;
            data1_q   <= '0;
            data2_q   <= '0;
            res_out_q <= '0;
            res_br_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_id_q  <= gnt_id_d;
            fun_q     <= fun_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            res_out_q <= res_out_d;
            res_br_q  <= res_br_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        fun_d     = fun_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        res_out_d = res_out_q;
        res_br_d  = res_br_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d  = S_EXEC;
                    gnt_id_d = arb_idx;
                    fun_d    = bus.req_fun[arb_idx];
                    data1_d  = bus.req_data1[arb_idx*WORD_LENGTH +: WORD_LENGTH];
                    data2_d  = bus.req_data2[arb_idx*WORD_LENGTH +: WORD_LENGTH];
                    // The winner becomes lowest priority next time.
                    rr_ptr_d = (arb_idx == RW'(NUM_REQ - 1)) ? '0 : arb_idx + RW'(1);
                end
            end
            S_EXEC: begin
                res_out_d = bus.alu_out;
                res_br_d  = bus.alu_br_flag;
                state_d   = S_RESP;
            end
            S_RESP: begin
                // Only the granted requester's rsp_ready completes the response.
                if (bus.rsp_ready[gnt_id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        // Gated by rst_n so nothing is accepted while reset is asserted.
        if (rst_n && state_q == S_IDLE && arb_any) begin
            bus.req_ready[arb_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            bus.rsp_valid[gnt_id_q] = 1'b1;
        end
        bus.busy         = (state_q != S_IDLE);
        bus.rsp_alu_out  = res_out_q;
        bus.rsp_br_flag  = res_br_q;
        bus.alu_exec_fun = fun_q;
        bus.alu_data1    = data1_q;
        bus.alu_data2    = data2_q;
    end
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// tb/tb_riscv_alu_arbiter.sv - directed self-checking bench for riscv_alu_arbiter
module tb_riscv_alu_arbiter;
    localparam int WL    = 32;
    localparam int NR    = 2;
    localparam int FW    = 4;
    localparam logic [FW-1:0] F_ADD = 4'd0;
    localparam logic [FW-1:0] F_SUB = 4'd1;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    riscv_alu_arbiter_if #(.WORD_LENGTH(WL), .NUM_REQ(NR), .FUN_W(FW)) bus ();

    riscv_alu_arbiter #(.WORD_LENGTH(WL), .NUM_REQ(NR), .FUN_W(FW), .ALU_ADD(F_ADD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared ALU model: ADD, SUB, anything else yields 0; branch-equal flag.
    assign bus.alu_out = (bus.alu_exec_fun == F_ADD) ? bus.alu_data1 + bus.alu_data2 :
                         (bus.alu_exec_fun == F_SUB) ? bus.alu_data1 - bus.alu_data2 : '0;
    assign bus.alu_br_flag = (bus.alu_data1 == bus.alu_data2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [FW-1:0] f,
                           input logic [WL-1:0] a, input logic [WL-1:0] b);
        bus.req_fun[id]            = f;
        bus.req_data1[id*WL +: WL] = a;
        bus.req_data2[id*WL +: WL] = b;
    endtask

    initial begin
        logic [NR-1:0] exp_g;
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_fun   = '0;
        bus.req_data1 = '0;
        bus.req_data2 = '0;
        tick();
        tick();
        check_eq("rst_busy",      bus.busy,         0);
        check_eq("rst_req_ready", bus.req_ready,    0);
        check_eq("rst_rsp_valid", bus.rsp_valid,    0);
        check_eq("rst_rsp_out",   bus.rsp_alu_out,  0);
        check_eq("rst_alu_fun",   bus.alu_exec_fun, F_ADD);
        check_eq("rst_alu_d1",    bus.alu_data1,    0);
        check_eq("rst_alu_d2",    bus.alu_data2,    0);
        rst_n = 1'b1;
        tick();

        // 1. single op on requester 0
        set_req(0, F_ADD, 5, 7);
        bus.req_valid = 2'b01;
        #1;
        check_eq("t1_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = '0;
        #1;
        check_eq("t1_busy",      bus.busy,      1);
        check_eq("t1_exec_rdy",  bus.req_ready, 0);
        check_eq("t1_exec_rsp",  bus.rsp_valid, 0);
        check_eq("t1_alu_d1",    bus.alu_data1, 5);
        check_eq("t1_alu_d2",    bus.alu_data2, 7);
        tick();
        check_eq("t1_rsp_valid", bus.rsp_valid,   2'b01);
        check_eq("t1_out",       bus.rsp_alu_out, 12);
        check_eq("t1_br",        bus.rsp_br_flag, 0);
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = '0;
        check_eq("t1_done_rsp",  bus.rsp_valid, 0);
        check_eq("t1_done_busy", bus.busy,      0);

        // 2. equal operands on requester 1; requester 0's rsp_ready ignored
        set_req(1, F_ADD, 9, 9);
        bus.req_valid = 2'b10;
        #1;
        check_eq("t2_req_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = '0;
        tick();
        check_eq("t2_rsp_valid", bus.rsp_valid,   2'b10);
        check_eq("t2_out",       bus.rsp_alu_out, 18);
        check_eq("t2_br",        bus.rsp_br_flag, 1);
        bus.rsp_ready = 2'b01;
        tick();
        check_eq("t2_wrong_rdy", bus.rsp_valid, 2'b10);
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = '0;
        check_eq("t2_done_rsp",  bus.rsp_valid, 0);

        // 4. backpressure on requester 0 with requester 1 waiting
        set_req(0, F_SUB, 10, 3);
        bus.req_valid = 2'b01;
        #1;
        check_eq("t4_req_ready", bus.req_ready, 2'b01);
        tick();
        set_req(1, F_ADD, 1, 2);
        bus.req_valid = 2'b10;
        #1;
        check_eq("t4_exec_rdy", bus.req_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_valid", bus.rsp_valid,   2'b01);
            check_eq("t4_hold_out",   bus.rsp_alu_out, 7);
            check_eq("t4_hold_br",    bus.rsp_br_flag, 0);
            check_eq("t4_hold_rdy",   bus.req_ready,   0);
            tick();
        end
        bus.rsp_ready = 2'b01;
        #1;
        check_eq("t4_last_valid", bus.rsp_valid, 2'b01);
        tick();
        bus.rsp_ready = '0;
        #1;
        check_eq("t4_next_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = '0;
        tick();
        check_eq("t4_r1_valid", bus.rsp_valid,   2'b10);
        check_eq("t4_r1_out",   bus.rsp_alu_out, 3);
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = '0;

        // 5. reset in EXEC after granting requester 0 (rr_ptr would be 1)
        set_req(0, F_ADD, 4, 4);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = '0;
        #1;
        check_eq("t5_in_exec", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_busy",  bus.busy,        0);
        check_eq("t5_rst_rsp",   bus.rsp_valid,   0);
        check_eq("t5_rst_rdy",   bus.req_ready,   0);
        check_eq("t5_rst_out",   bus.rsp_alu_out, 0);
        check_eq("t5_rst_d1",    bus.alu_data1,   0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5_no_rsp",  bus.rsp_valid, 0);
            check_eq("t5_no_busy", bus.busy,      0);
        end

        // 3. contention: both valid, grants must start at 0 and alternate
        set_req(0, F_ADD, 20, 22);
        set_req(1, F_SUB, 30, 8);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check_eq("t3_grant", bus.req_ready, exp_g);
            tick();
            tick();
            check_eq("t3_rsp_valid", bus.rsp_valid, exp_g);
            check_eq("t3_out", bus.rsp_alu_out, (k % 2 == 0) ? 42 : 22);
            bus.rsp_ready = exp_g;
            tick();
            bus.rsp_ready = '0;
        end
        bus.req_valid = '0;

        // 6. idle
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t6_busy", bus.busy,      0);
            check_eq("t6_rdy",  bus.req_ready, 0);
            check_eq("t6_rsp",  bus.rsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
